// File: rtl/combo_lock_pkg.sv
// Shared state encoding and helpers for the parametrised combination lock.
package combo_lock_pkg;

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  // Widest keypad the one-hot helper accepts; narrower vectors are zero-extended.
  localparam int unsigned OneHotW = 32;

  function automatic logic is_onehot(input logic [OneHotW-1:0] v);
    return (v != '0) && ((v & (v - OneHotW'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Rising-edge detector for the keypad: a press is any key set while none was set last cycle.
module key_press_detect
  import combo_lock_pkg::*;
#(
  parameter int unsigned KEY_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [KEY_W-1:0] keys_i,
  output logic             press_o,
  output logic [KEY_W-1:0] press_key_o,
  output logic             press_valid_o
);

  logic [KEY_W-1:0] keys_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      keys_q <= '0;
    end else begin
      keys_q <= keys_i;
    end
  end

  assign press_o       = (keys_i != '0) && (keys_q == '0);
  assign press_key_o   = keys_i;
  assign press_valid_o = is_onehot(OneHotW'(keys_i));

endmodule

// File: rtl/param_combo_lock.sv
// Moore combination lock with programmable code, timed unlock and timed lockout after
// repeated wrong digits.
module param_combo_lock
  import combo_lock_pkg::*;
#(
  parameter int unsigned KEY_W          = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [KEY_W-1:0]                 keys_i,
  input  logic [CODE_LEN*KEY_W-1:0]        code_i,
  output logic                             unlock_o,
  output logic [CODE_LEN-1:0]              progress_o,
  output logic                             locked_out_o,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count_o
);

  localparam int unsigned MatchW   = $clog2(CODE_LEN);
  localparam int unsigned FailW    = $clog2(MAX_FAILS + 1);
  localparam int unsigned TimerMax = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  localparam logic [MatchW-1:0] LastDigit   = MatchW'(CODE_LEN - 1);
  localparam logic [FailW-1:0]  FailMax     = FailW'(MAX_FAILS);
  localparam logic [FailW-1:0]  FailLast    = FailW'(MAX_FAILS - 1);
  localparam logic [TimerW-1:0] UnlockLoad  = TimerW'(UNLOCK_CYCLES);
  localparam logic [TimerW-1:0] LockoutLoad = TimerW'(LOCKOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerLast   = TimerW'(1);

  logic                            press;
  logic [KEY_W-1:0]                press_key;
  logic                            press_valid;
  logic [CODE_LEN-1:0][KEY_W-1:0]  code_digits;
  logic [KEY_W-1:0]                digit;

  logic [1:0]          state_q, state_d;
  logic [MatchW-1:0]   matched_q, matched_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [FailW-1:0]    fail_q, fail_d;
  logic                unlock_q, unlock_d;
  logic                locked_out_q, locked_out_d;
  logic [CODE_LEN-1:0] progress_q, progress_d;

  key_press_detect #(
    .KEY_W (KEY_W)
  ) u_key_press_detect (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .keys_i        (keys_i),
    .press_o       (press),
    .press_key_o   (press_key),
    .press_valid_o (press_valid)
  );

  // Digit 0 sits in the least significant KEY_W bits and is entered first.
  assign code_digits = code_i;
  assign digit       = code_digits[matched_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_ENTRY;
      matched_q    <= '0;
      timer_q      <= '0;
      fail_q       <= '0;
      unlock_q     <= 1'b0;
      locked_out_q <= 1'b0;
      progress_q   <= '0;
    end else begin
      state_q      <= state_d;
      matched_q    <= matched_d;
      timer_q      <= timer_d;
      fail_q       <= fail_d;
      unlock_q     <= unlock_d;
      locked_out_q <= locked_out_d;
      progress_q   <= progress_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    matched_d = matched_q;
    timer_d   = timer_q;
    fail_d    = fail_q;
    unique case (state_q)
      ST_ENTRY: begin
        if (press) begin
          if (press_valid && (press_key == digit)) begin
            if (matched_q == LastDigit) begin
              state_d   = ST_OPEN;
              matched_d = '0;
              timer_d   = UnlockLoad;
              fail_d    = '0;
            end else begin
              matched_d = matched_q + 1'b1;
            end
          end else begin
            // A wrong press restarts the attempt and is never taken as digit 0.
            matched_d = '0;
            if (fail_q == FailLast) begin
              state_d = ST_LOCKOUT;
              timer_d = LockoutLoad;
              fail_d  = FailMax;
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end
      end
      ST_OPEN, ST_LOCKOUT: begin
        if (timer_q == TimerLast) begin
          state_d   = ST_ENTRY;
          matched_d = '0;
          timer_d   = '0;
          fail_d    = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d   = ST_ENTRY;
        matched_d = '0;
        timer_d   = '0;
        fail_d    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change only on clk.
  always_comb begin
    unlock_d     = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
    progress_d   = '0;
    if (state_d == ST_OPEN) begin
      progress_d = '1;
    end else if (state_d == ST_ENTRY) begin
      for (int unsigned i = 0; i < CODE_LEN; i++) begin
        progress_d[i] = (MatchW'(i) < matched_d);
      end
    end
  end

  assign unlock_o     = unlock_q;
  assign locked_out_o = locked_out_q;
  assign progress_o   = progress_q;
  assign fail_count_o = fail_q;

endmodule

// File: tb/tb_param_combo_lock.sv
// Bench for param_combo_lock: directed vector table, hand sequences and a randomized run
// checked against a cycle-count reference model.
module tb_param_combo_lock;

  localparam int unsigned KEY_W          = 4;
  localparam int unsigned CODE_LEN       = 4;
  localparam int unsigned MAX_FAILS      = 3;
  localparam int unsigned UNLOCK_CYCLES  = 8;
  localparam int unsigned LOCKOUT_CYCLES = 16;
  localparam int unsigned FAIL_W         = $clog2(MAX_FAILS + 1);

  localparam int MEntry = 0;
  localparam int MOpen  = 1;
  localparam int MLock  = 2;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic [KEY_W-1:0]            keys_i;
  logic [CODE_LEN*KEY_W-1:0]   code_i;
  logic                        unlock_o;
  logic [CODE_LEN-1:0]         progress_o;
  logic                        locked_out_o;
  logic [FAIL_W-1:0]           fail_count_o;

  always #5 clk_i = ~clk_i;

  param_combo_lock #(
    .KEY_W          (KEY_W),
    .CODE_LEN       (CODE_LEN),
    .MAX_FAILS      (MAX_FAILS),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .keys_i       (keys_i),
    .code_i       (code_i),
    .unlock_o     (unlock_o),
    .progress_o   (progress_o),
    .locked_out_o (locked_out_o),
    .fail_count_o (fail_count_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode, digits matched, failures, cycles left in OPEN/LOCKOUT.
  int m_mode;
  int m_matched;
  int m_fail;
  int m_left;
  int m_prev;

  typedef struct {
    logic [KEY_W-1:0]    keys;
    logic [CODE_LEN-1:0] prog;
    logic                unl;
    logic                lo;
    int                  fail;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input int prog, input int unl, input int lo,
                            input int fail);
    check({name, ".progress"}, int'(progress_o), prog);
    check({name, ".unlock"}, int'(unlock_o), unl);
    check({name, ".locked_out"}, int'(locked_out_o), lo);
    check({name, ".fail_count"}, int'(fail_count_o), fail);
  endtask

  function automatic void model_reset();
    m_mode    = MEntry;
    m_matched = 0;
    m_fail    = 0;
    m_left    = 0;
    m_prev    = 0;
  endfunction

  function automatic int model_digit(input int idx);
    return int'((code_i >> (idx * KEY_W)) & ((1 << KEY_W) - 1));
  endfunction

  function automatic void model_step(input int k);
    bit press;
    press  = (k != 0) && (m_prev == 0);
    m_prev = k;
    if (m_mode == MEntry) begin
      if (press) begin
        if ($countones(k) == 1 && k == model_digit(m_matched)) begin
          m_matched++;
          if (m_matched == CODE_LEN) begin
            m_mode    = MOpen;
            m_left    = UNLOCK_CYCLES;
            m_matched = 0;
            m_fail    = 0;
          end
        end else begin
          m_matched = 0;
          m_fail++;
          if (m_fail == MAX_FAILS) begin
            m_mode = MLock;
            m_left = LOCKOUT_CYCLES;
          end
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == MLock) m_fail = 0;
        m_mode    = MEntry;
        m_matched = 0;
      end
    end
  endfunction

  function automatic int model_progress();
    if (m_mode == MOpen) return (1 << CODE_LEN) - 1;
    if (m_mode == MLock) return 0;
    return (1 << m_matched) - 1;
  endfunction

  task automatic tick(input logic [KEY_W-1:0] k);
    keys_i = k;
    @(posedge clk_i);
    model_step(int'(k));
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    keys_i = '0;
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  function automatic void add(input int k, input int prog, input int unl, input int lo,
                              input int fail);
    vec_t v;
    v.keys = KEY_W'(k);
    v.prog = CODE_LEN'(prog);
    v.unl  = unl[0];
    v.lo   = lo[0];
    v.fail = fail;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [KEY_W-1:0] k;
    logic [KEY_W-1:0] last_k;
    int r;

    // Correct entry, 8-cycle unlock window.
    add(1, 4'b0001, 0, 0, 0); add(0, 4'b0001, 0, 0, 0);
    add(2, 4'b0011, 0, 0, 0); add(0, 4'b0011, 0, 0, 0);
    add(4, 4'b0111, 0, 0, 0); add(0, 4'b0111, 0, 0, 0);
    add(8, 4'b1111, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 4'b1111, 1, 0, 0);
    add(0, 4'b0000, 0, 0, 0);
    // Wrong third digit, then a clean retry.
    add(1, 4'b0001, 0, 0, 0); add(0, 4'b0001, 0, 0, 0);
    add(2, 4'b0011, 0, 0, 0); add(0, 4'b0011, 0, 0, 0);
    add(8, 4'b0000, 0, 0, 1); add(0, 4'b0000, 0, 0, 1);
    add(1, 4'b0001, 0, 0, 1); add(0, 4'b0001, 0, 0, 1);
    add(2, 4'b0011, 0, 0, 1); add(0, 4'b0011, 0, 0, 1);
    add(4, 4'b0111, 0, 0, 1); add(0, 4'b0111, 0, 0, 1);
    add(8, 4'b1111, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 4'b1111, 1, 0, 0);
    add(0, 4'b0000, 0, 0, 0);
    // Non-one-hot press as the first digit.
    add(3, 4'b0000, 0, 0, 1); add(0, 4'b0000, 0, 0, 1);

    code_i = 16'h8421;
    keys_i = '0;
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_outs("reset", 0, 0, 0, 0);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      tick(vecs[i].keys);
      check_outs($sformatf("vec%0d", i), int'(vecs[i].prog), int'(vecs[i].unl),
                 int'(vecs[i].lo), vecs[i].fail);
    end

    // Asynchronous reset while OPEN clears outputs without a clock edge.
    do_reset();
    tick(1); tick(0); tick(2); tick(0); tick(4); tick(0); tick(8); tick(0);
    check_outs("pre_async_reset", 4'b1111, 1, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_outs("async_reset", 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(0);
    check_outs("after_release", 0, 0, 0, 0);

    // Holding a key counts as one press.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_outs($sformatf("hold%0d", i), 4'b0001, 0, 0, 0);
    end
    tick(0);
    tick(2);
    check_outs("hold_next_digit", 4'b0011, 0, 0, 0);

    // Lockout after three wrong presses; keypad ignored for 16 cycles.
    do_reset();
    tick(2); tick(0);
    check_outs("wrong1", 0, 0, 0, 1);
    tick(2); tick(0);
    check_outs("wrong2", 0, 0, 0, 2);
    tick(2);
    check_outs("lock_c1", 0, 0, 1, MAX_FAILS);
    for (int c = 2; c <= LOCKOUT_CYCLES; c++) begin
      if (c == LOCKOUT_CYCLES) k = 4'b0001;
      else if (c % 2 == 0) k = KEY_W'(1 << ((c / 2 - 1) % 4));
      else k = '0;
      tick(k);
      check_outs($sformatf("lock_c%0d", c), 0, 0, 1, MAX_FAILS);
    end
    tick(1);
    check_outs("lock_exit_held", 0, 0, 0, 0);
    tick(1);
    check_outs("lock_exit_held2", 0, 0, 0, 0);
    tick(0); tick(1); tick(0); tick(2); tick(0); tick(4); tick(0); tick(8);
    check_outs("unlock_after_lockout", 4'b1111, 1, 0, 0);

    // Randomized run against the reference model, with occasional code changes.
    do_reset();
    last_k = '0;
    for (int n = 0; n < 800; n++) begin
      if (n % 53 == 0) begin
        for (int d = 0; d < CODE_LEN; d++) begin
          code_i[d*KEY_W +: KEY_W] = KEY_W'(1 << $urandom_range(0, KEY_W - 1));
        end
      end
      r = int'($urandom_range(0, 9));
      if (r <= 3) k = '0;
      else if (r <= 6) k = (m_mode == MEntry) ? KEY_W'(model_digit(m_matched))
                                             : KEY_W'($urandom_range(1, 15));
      else if (r == 7) k = KEY_W'(1 << $urandom_range(0, KEY_W - 1));
      else if (r == 8) k = KEY_W'($urandom_range(0, 15));
      else k = last_k;
      last_k = k;
      tick(k);
      check_outs($sformatf("rand%0d", n), model_progress(), int'(m_mode == MOpen),
                 int'(m_mode == MLock), m_fail);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
